// File: rtl/pc_gen_multi.sv
// Fetch PC generator: holds the fetch PC, arbitrates prioritised redirects and
// tags each presented PC with an epoch so wrong-path fetches can be dropped.
module pc_gen_multi #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h8000_0000),
  parameter int unsigned     INC       = 4,
  parameter int unsigned     NUM_REDIR = 3,
  parameter int unsigned     EPOCH_W   = 3,
  parameter int unsigned     BYPASS    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
  input  logic                      halt,
  input  logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [XLEN-1:0]           fetch_pc,
  output logic [EPOCH_W-1:0]        fetch_epoch,
  output logic [NUM_REDIR-1:0]      redir_taken
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(INC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      pc_q, pc_d, sel_pc;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d, epoch_inc;
  logic [NUM_REDIR-1:0] redir_req, grant;
  logic                 redir, fire, found;

  // Requests are masked while reset is low so outputs show reset values at once.
  assign redir_req   = redir_valid & {NUM_REDIR{reset}};
  assign redir_taken = grant;

  // Fixed-priority arbiter: lowest channel index wins.
  always_comb begin
    grant  = '0;
    sel_pc = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REDIR; i++) begin
      if (redir_req[i] && !found) begin
        grant[i] = 1'b1;
        sel_pc   = redir_pc[i*XLEN +: XLEN];
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_valid = 1'b0;
    fetch_pc    = pc_q;
    fetch_epoch = epoch_q;
    pc_d        = pc_q;
    redir       = |grant;
    epoch_inc   = epoch_q + EPOCH_W'(1);
    epoch_d     = redir ? epoch_inc : epoch_q;

    case (state_q)
      ST_BOOT: state_d = halt ? ST_HALT : ST_RUN;
      ST_RUN: begin
        fetch_valid = 1'b1;
        state_d     = halt ? ST_HALT : ST_RUN;
      end
      ST_HALT: state_d = halt ? ST_HALT : ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    fire = fetch_valid & fetch_ready;

    // In bypass mode the target is presented now; otherwise it appears next cycle.
    if (redir) begin
      if (BYPASS != 0) begin
        fetch_pc    = sel_pc;
        fetch_epoch = epoch_inc;
        pc_d        = fire ? sel_pc + PC_INC : sel_pc;
      end else begin
        pc_d = sel_pc;
      end
    end else if (fire) begin
      pc_d = pc_q + PC_INC;
    end
  end

endmodule

// File: tb/tb_pc_gen_multi.sv
// Bench for pc_gen_multi: bypass and registered instances share stimulus and
// are checked every cycle against a behavioural model plus directed literals.
module tb_pc_gen_multi;

  logic         clock, reset;
  logic [2:0]   redir_valid;
  logic [191:0] redir_pc;
  logic         halt, fetch_ready;

  logic         v1, v0;
  logic [63:0]  pc1, pc0;
  logic [2:0]   ep1, ep0, tk1, tk0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          chk_en = 1'b0;

  // Model state per instance: index 1 = bypass, index 0 = registered.
  logic [63:0] m_pc [2];
  logic [2:0]  m_ep [2];
  bit          m_run [2];

  pc_gen_multi #(.BYPASS(1)) u_byp (
    .clock(clock), .reset(reset), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt(halt), .fetch_ready(fetch_ready), .fetch_valid(v1), .fetch_pc(pc1),
    .fetch_epoch(ep1), .redir_taken(tk1)
  );

  pc_gen_multi #(.BYPASS(0)) u_reg (
    .clock(clock), .reset(reset), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt(halt), .fetch_ready(fetch_ready), .fetch_valid(v0), .fetch_pc(pc0),
    .fetch_epoch(ep0), .redir_taken(tk0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_ch(input logic [2:0] rv);
    for (int i = 0; i < 3; i++) if (rv[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] tgt(input int ch);
    return redir_pc[ch*64 +: 64];
  endfunction

  // Architectural model: advance on each rising edge from the current inputs.
  always @(posedge clock or negedge reset) begin : model
    int ch;
    bit f;
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_pc[m]  <= 64'h8000_0000;
        m_ep[m]  <= 3'd0;
        m_run[m] <= 1'b0;
      end
    end else begin
      ch = first_ch(redir_valid);
      for (int m = 0; m < 2; m++) begin
        f = m_run[m] && fetch_ready;
        if (ch >= 0) begin
          m_ep[m] <= m_ep[m] + 3'd1;
          m_pc[m] <= (m == 1 && f) ? tgt(ch) + 64'd4 : tgt(ch);
        end else if (f) begin
          m_pc[m] <= m_pc[m] + 64'd4;
        end
        m_run[m] <= !halt;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin : cmp
    int ch;
    logic [2:0]  e_tk, e_ep;
    logic [63:0] e_pc;
    if (chk_en && reset) begin
      ch   = first_ch(redir_valid);
      e_tk = (ch < 0) ? 3'b000 : 3'(1 << ch);
      e_pc = (ch >= 0) ? tgt(ch) : m_pc[1];
      e_ep = (ch >= 0) ? m_ep[1] + 3'd1 : m_ep[1];
      chk("byp_valid", 64'(v1), 64'(m_run[1]));
      chk("byp_pc",    pc1,      e_pc);
      chk("byp_epoch", 64'(ep1), 64'(e_ep));
      chk("byp_taken", 64'(tk1), 64'(e_tk));
      chk("reg_valid", 64'(v0),  64'(m_run[0]));
      chk("reg_pc",    pc0,      m_pc[0]);
      chk("reg_epoch", 64'(ep0), 64'(m_ep[0]));
      chk("reg_taken", 64'(tk0), 64'(e_tk));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_redir(input logic [2:0] rv, input logic [63:0] p0,
                           input logic [63:0] p1, input logic [63:0] p2);
    redir_valid = rv;
    redir_pc[0   +: 64] = p0;
    redir_pc[64  +: 64] = p1;
    redir_pc[128 +: 64] = p2;
  endtask

  logic [2:0] pats [8];

  initial begin
    pats = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b110, 3'b011, 3'b101, 3'b001};
    reset = 1'b1; halt = 1'b0; fetch_ready = 1'b1;
    set_redir(3'b000, 64'd0, 64'd0, 64'd0);
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", 64'(v1),  64'd0);
    chk("rst_pc",    pc1,      64'h8000_0000);
    chk("rst_epoch", 64'(ep1), 64'd0);
    chk("rst_taken", 64'(tk1), 64'd0);
    tick(); tick();
    reset = 1'b1; chk_en = 1'b1;

    // Boot then sequential fetch.
    @(negedge clock); chk("boot_valid", 64'(v1), 64'd0); tick();
    @(negedge clock); chk("seq_pc0", pc1, 64'h8000_0000); chk("seq_v", 64'(v1), 64'd1); tick();
    @(negedge clock); chk("seq_pc1", pc1, 64'h8000_0004); tick();

    // Stall: PC must hold.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); chk("stall_pc", pc1, 64'h8000_0008); chk("stall_v", 64'(v1), 64'd1); tick();
    end
    fetch_ready = 1'b1;
    @(negedge clock); chk("resume_pc", pc1, 64'h8000_0008); tick();
    @(negedge clock); chk("seq_pc3", pc1, 64'h8000_000C); tick();

    // Simultaneous ch1/ch2 redirect: ch1 wins.
    set_redir(3'b110, 64'd0, 64'h8000_1000, 64'h8000_2000);
    @(negedge clock);
    chk("arb_taken", 64'(tk1), 64'h2);
    chk("arb_pc", pc1, 64'h8000_1000);
    chk("arb_epoch", 64'(ep1), 64'd1);
    chk("reg_old_pc", pc0, 64'h8000_0010);
    tick(); set_redir(3'b000, 64'd0, 64'd0, 64'd0);
    @(negedge clock);
    chk("arb_next_pc", pc1, 64'h8000_1004);
    chk("reg_tgt_pc", pc0, 64'h8000_1000);
    chk("reg_tgt_ep", 64'(ep0), 64'd1);
    tick();

    // Registered-mode redirect on ch0.
    set_redir(3'b001, 64'h8000_3000, 64'd0, 64'd0);
    @(negedge clock); chk("reg_r2_old", pc0, 64'h8000_1004); chk("byp_r2_pc", pc1, 64'h8000_3000); tick();
    set_redir(3'b000, 64'd0, 64'd0, 64'd0);
    @(negedge clock); chk("reg_r2_pc", pc0, 64'h8000_3000); chk("reg_r2_ep", 64'(ep0), 64'd2); tick();

    // Halt together with redirect, then resume at the target.
    halt = 1'b1; fetch_ready = 1'b0;
    set_redir(3'b001, 64'h8000_4000, 64'd0, 64'd0);
    @(negedge clock); chk("halt_redir_pc", pc1, 64'h8000_4000); tick();
    set_redir(3'b000, 64'd0, 64'd0, 64'd0); fetch_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); chk("halted_v", 64'(v1), 64'd0); chk("halted_v0", 64'(v0), 64'd0); tick();
    end
    halt = 1'b0;
    @(negedge clock); chk("unhalt_v", 64'(v1), 64'd0); tick();
    @(negedge clock);
    chk("resume_v", 64'(v1), 64'd1);
    chk("resume_tgt1", pc1, 64'h8000_4000);
    chk("resume_tgt0", pc0, 64'h8000_4000);
    chk("resume_ep", 64'(ep1), 64'd3);
    tick();

    // PC wrap at the top of the address space.
    set_redir(3'b100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clock); chk("wrap_taken", 64'(tk1), 64'h4); chk("wrap_pc_top", pc1, 64'hFFFF_FFFF_FFFF_FFFC); tick();
    set_redir(3'b000, 64'd0, 64'd0, 64'd0);
    @(negedge clock); chk("wrap_byp", pc1, 64'd0); chk("wrap_reg_top", pc0, 64'hFFFF_FFFF_FFFF_FFFC); tick();
    @(negedge clock); chk("wrap_reg", pc0, 64'd0); tick();

    // Asynchronous reset mid-stream with a pending request.
    set_redir(3'b001, 64'h8000_9000, 64'd0, 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(v1),  64'd0);
    chk("arst_pc",    pc1,      64'h8000_0000);
    chk("arst_epoch", 64'(ep1), 64'd0);
    chk("arst_taken", 64'(tk1), 64'd0);
    chk("arst_pc0",   pc0,      64'h8000_0000);
    set_redir(3'b000, 64'd0, 64'd0, 64'd0);
    tick();
    reset = 1'b1;

    // Eight redirects from epoch 0, starting in the boot cycle.
    for (int i = 0; i < 8; i++) begin
      set_redir(pats[i], 64'h8000_5000 + 64'(i*16), 64'h8000_5004 + 64'(i*16),
                64'h8000_5008 + 64'(i*16));
      @(negedge clock);
      tick();
    end
    set_redir(3'b000, 64'd0, 64'd0, 64'd0);
    @(negedge clock); chk("ep_wrap1", 64'(ep1), 64'd0); chk("ep_wrap0", 64'(ep0), 64'd0); tick();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
